// File: rtl/servo_pkg.sv
// Shared types and byte constants for the host side of the byte-parallel servo link.
// Command codes, decoded disc/tray state, error causes and the fixed link bytes.
package servo_pkg;

  typedef enum logic [1:0] {
    CMD_STATUS  = 2'd0,
    CMD_OPEN    = 2'd1,
    CMD_CLOSE   = 2'd2,
    CMD_ILLEGAL = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    NO_DISC = 2'd0,
    CDI     = 2'd1,
    AUDIO   = 2'd2
  } disc_t;

  typedef enum logic {
    TRAY_CLOSED = 1'b0,
    TRAY_OPEN   = 1'b1
  } tray_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_SYNC        = 3'd1,
    ERR_CMD_ACK     = 3'd2,
    ERR_HDR         = 3'd3,
    ERR_TIMEOUT     = 3'd4,
    ERR_ILLEGAL_CMD = 3'd5,
    ERR_REPORT      = 3'd6
  } err_t;

  localparam logic [7:0] BYTE_SYNC     = 8'hDD;
  localparam logic [7:0] BYTE_SYNC_ACK = 8'hEE;
  localparam logic [7:0] BYTE_CMD_ACK  = 8'h55;
  localparam logic [7:0] BYTE_STATUS   = 8'hB0;
  localparam logic [7:0] BYTE_OPEN     = 8'hA6;
  localparam logic [7:0] BYTE_CLOSE    = 8'hA7;
  localparam logic [7:0] BYTE_HDR0     = 8'h61;
  localparam logic [7:0] BYTE_HDR12    = 8'h01;
  localparam logic [7:0] BYTE_POLL     = 8'hAA;
  localparam logic [7:0] BYTE_RPT0     = 8'h03;
  localparam logic [7:0] BYTE_ZERO     = 8'h00;

  localparam logic [7:0] RPT_AUDIO   = 8'h01;
  localparam logic [7:0] RPT_CDI     = 8'h02;
  localparam logic [7:0] RPT_NO_DISC = 8'h03;
  localparam logic [7:0] RPT_OPEN    = 8'h21;
  localparam logic [7:0] RPT_CLOSED  = 8'h25;

  function automatic logic [7:0] cmd_byte(input cmd_t code);
    case (code)
      CMD_OPEN:  cmd_byte = BYTE_OPEN;
      CMD_CLOSE: cmd_byte = BYTE_CLOSE;
      default:   cmd_byte = BYTE_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/servo_byte_pacer.sv
// Byte strobe generator: enforces BYTE_GAP idle cycles before every spi_write.
// done mirrors the write cycle; rx_byte is the slave reply sampled on that same cycle.
module servo_byte_pacer #(
  parameter int BYTE_GAP = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [7:0] tx_byte,
  input  logic [7:0] spi_miso,
  output logic       spi_write,
  output logic [7:0] spi_mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int GW = $clog2(BYTE_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_GAP);

  logic [GW-1:0] gap_cnt;
  logic          issue;

  // The reload on issue means the down-count overlaps the strobe cycle itself.
  assign issue = req && (gap_cnt == '0) && !spi_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt   <= GAP_LOAD;
      spi_write <= 1'b0;
      spi_mosi  <= 8'hFF;
    end else begin
      spi_write <= issue;
      if (issue) begin
        spi_mosi <= tx_byte;
        gap_cnt  <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  assign done    = spi_write;
  assign rx_byte = spi_miso;

endmodule

// File: rtl/servo_cmd_master.sv
// Host-side servo link initiator: sync, command/header exchange, mode-fault wait
// and 5-byte status report decode into disc/tray state.
module servo_cmd_master
  import servo_pkg::*;
#(
  parameter int BYTE_GAP   = 16,
  parameter int MF_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_code,
  output logic       cmd_ready,
  output logic       spi_write,
  output logic [7:0] spi_mosi,
  input  logic [7:0] spi_miso,
  input  logic       mode_fault,
  output logic       status_valid,
  output logic [1:0] disc_state,
  output logic       tray_state,
  output logic       proto_err,
  output logic [2:0] err_code,
  output logic       busy
);

  // state      | meaning
  // ST_SYNC    | send DD until the servo answers EE
  // ST_IDLE    | ready for a command or an unsolicited report
  // ST_CMD     | send command byte, expect 55
  // ST_HDR     | three 00 writes, expect 61 01 01
  // ST_WAIT_MF | no traffic, wait for the mode-fault edge
  // ST_RPT     | five AA writes collecting the status report
  typedef enum logic [2:0] {
    ST_SYNC, ST_IDLE, ST_CMD, ST_HDR, ST_WAIT_MF, ST_RPT
  } state_t;

  localparam int TW = (MF_TIMEOUT > 0) ? $clog2(MF_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(MF_TIMEOUT);

  state_t        state, state_nx;
  logic [2:0]    idx, idx_nx, idx_inc;
  cmd_t          code, code_nx;
  logic [TW-1:0] tmo, tmo_nx;
  disc_t         disc_tmp, disc_tmp_nx, disc_r, disc_nx;
  tray_t         tray_r, tray_nx, tray_dec;
  err_t          err_r, err_nx;
  logic          sv_nx, pe_nx, mf_q, mf_rise, rpt_ok;
  logic          req, done;
  logic [7:0]    tx_byte, rx_byte, hdr_exp;

  servo_byte_pacer #(.BYTE_GAP(BYTE_GAP)) u_pacer (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .tx_byte   (tx_byte),
    .spi_miso  (spi_miso),
    .spi_write (spi_write),
    .spi_mosi  (spi_mosi),
    .done      (done),
    .rx_byte   (rx_byte)
  );

  assign mf_rise = mode_fault && !mf_q;
  assign idx_inc = (idx == 3'd7) ? idx : idx + 3'd1;
  assign hdr_exp = (idx == 3'd0) ? BYTE_HDR0 : BYTE_HDR12;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_SYNC;
      idx          <= 3'd0;
      code         <= CMD_STATUS;
      tmo          <= TMO_LOAD;
      disc_tmp     <= NO_DISC;
      disc_r       <= NO_DISC;
      tray_r       <= TRAY_CLOSED;
      err_r        <= ERR_NONE;
      status_valid <= 1'b0;
      proto_err    <= 1'b0;
      mf_q         <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      code         <= code_nx;
      tmo          <= tmo_nx;
      disc_tmp     <= disc_tmp_nx;
      disc_r       <= disc_nx;
      tray_r       <= tray_nx;
      err_r        <= err_nx;
      status_valid <= sv_nx;
      proto_err    <= pe_nx;
      mf_q         <= mode_fault;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    code_nx     = code;
    tmo_nx      = tmo;
    disc_tmp_nx = disc_tmp;
    disc_nx     = disc_r;
    tray_nx     = tray_r;
    err_nx      = err_r;
    sv_nx       = 1'b0;
    pe_nx       = 1'b0;
    req         = 1'b0;
    tx_byte     = BYTE_SYNC;
    rpt_ok      = 1'b1;
    tray_dec    = TRAY_CLOSED;
    case (state)
      ST_SYNC: begin
        req     = 1'b1;
        tx_byte = BYTE_SYNC;
        if (done) begin
          if (rx_byte == BYTE_SYNC_ACK) begin
            state_nx = ST_IDLE;
          end else begin
            err_nx = ERR_SYNC;
            pe_nx  = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        // A mode-fault edge beats a simultaneous command; the command stays pending.
        if (mf_rise) begin
          state_nx = ST_RPT;
          idx_nx   = 3'd0;
        end else if (cmd_valid) begin
          if (cmd_t'(cmd_code) == CMD_ILLEGAL) begin
            err_nx = ERR_ILLEGAL_CMD;
            pe_nx  = 1'b1;
          end else begin
            code_nx  = cmd_t'(cmd_code);
            state_nx = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        req     = 1'b1;
        tx_byte = cmd_byte(code);
        if (done) begin
          if (rx_byte == BYTE_CMD_ACK) begin
            state_nx = ST_HDR;
            idx_nx   = 3'd0;
          end else begin
            err_nx   = ERR_CMD_ACK;
            pe_nx    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_HDR: begin
        req     = 1'b1;
        tx_byte = BYTE_ZERO;
        if (done) begin
          if (rx_byte != hdr_exp) begin
            err_nx   = ERR_HDR;
            pe_nx    = 1'b1;
            state_nx = ST_IDLE;
          end else if (idx == 3'd2) begin
            state_nx = ST_WAIT_MF;
            tmo_nx   = TMO_LOAD;
          end else begin
            idx_nx = idx_inc;
          end
        end
      end
      ST_WAIT_MF: begin
        if (mf_rise) begin
          state_nx = ST_RPT;
          idx_nx   = 3'd0;
        end else if (MF_TIMEOUT != 0) begin
          if (tmo == '0) begin
            err_nx   = ERR_TIMEOUT;
            pe_nx    = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            tmo_nx = tmo - TW'(1);
          end
        end
      end
      ST_RPT: begin
        req     = 1'b1;
        tx_byte = BYTE_POLL;
        if (done) begin
          case (idx)
            3'd0: rpt_ok = (rx_byte == BYTE_RPT0);
            3'd1: rpt_ok = (rx_byte == BYTE_STATUS);
            3'd2: rpt_ok = (rx_byte == BYTE_ZERO);
            3'd3: begin
              case (rx_byte)
                RPT_CDI:     disc_tmp_nx = CDI;
                RPT_AUDIO:   disc_tmp_nx = AUDIO;
                RPT_NO_DISC: disc_tmp_nx = NO_DISC;
                default:     rpt_ok = 1'b0;
              endcase
            end
            3'd4: begin
              case (rx_byte)
                RPT_CLOSED: tray_dec = TRAY_CLOSED;
                RPT_OPEN:   tray_dec = TRAY_OPEN;
                default:    rpt_ok = 1'b0;
              endcase
            end
            default: rpt_ok = 1'b0;
          endcase
          // Decoded state is published only once the whole report checks out.
          if (!rpt_ok) begin
            err_nx   = ERR_REPORT;
            pe_nx    = 1'b1;
            state_nx = ST_IDLE;
          end else if (idx == 3'd4) begin
            disc_nx  = disc_tmp;
            tray_nx  = tray_dec;
            sv_nx    = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx_inc;
          end
        end
      end
      default: state_nx = ST_SYNC;
    endcase
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = !cmd_ready;
  assign disc_state = disc_r;
  assign tray_state = tray_r;
  assign err_code   = err_r;

endmodule

// File: tb/tb_servo_cmd_master.sv
// Directed bench for servo_cmd_master with a scripted servo slave: expected MOSI bytes and
// slave replies are queued per step and consumed as the DUT strobes spi_write.
module tb_servo_cmd_master;

  localparam int BYTE_GAP   = 4;
  localparam int MF_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_code = 2'd0;
  logic       mode_fault = 1'b0;
  logic [7:0] spi_miso = 8'h00;
  logic       cmd_ready, spi_write, status_valid, tray_state, proto_err, busy;
  logic [7:0] spi_mosi;
  logic [1:0] disc_state;
  logic [2:0] err_code;

  int checks = 0;
  int failures = 0;
  int sv_cnt = 0;
  int pe_cnt = 0;
  int idle_cnt = 0;
  bit gap_valid = 1'b0;
  bit wr_seen = 1'b0;
  logic [7:0] exp_mosi[$];
  logic [7:0] miso_q[$];

  servo_cmd_master #(.BYTE_GAP(BYTE_GAP), .MF_TIMEOUT(MF_TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_ready    (cmd_ready),
    .spi_write    (spi_write),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .mode_fault   (mode_fault),
    .status_valid (status_valid),
    .disc_state   (disc_state),
    .tray_state   (tray_state),
    .proto_err    (proto_err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scripted slave: holds the current reply steady through each write cycle, advances after it.
  always @(negedge clk) begin
    if (!reset_n) begin
      gap_valid = 1'b0;
      wr_seen   = 1'b0;
      idle_cnt  = 0;
      spi_miso  = (miso_q.size() > 0) ? miso_q[0] : 8'h00;
    end else if (spi_write) begin
      checks++;
      assert (exp_mosi.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write: mosi=%0h with no byte expected", spi_mosi);
      end
      if (exp_mosi.size() != 0) check("mosi_byte", spi_mosi, exp_mosi.pop_front());
      if (gap_valid) check("byte_gap_ok", (idle_cnt >= BYTE_GAP), 1);
      gap_valid = 1'b1;
      idle_cnt  = 0;
      wr_seen   = 1'b1;
    end else begin
      idle_cnt++;
      if (wr_seen) begin
        wr_seen = 1'b0;
        if (miso_q.size() > 0) void'(miso_q.pop_front());
      end
      spi_miso = (miso_q.size() > 0) ? miso_q[0] : 8'h00;
    end
    if (status_valid) sv_cnt++;
    if (proto_err) pe_cnt++;
  end

  task automatic push(input logic [7:0] m, input logic [7:0] s);
    exp_mosi.push_back(m);
    miso_q.push_back(s);
  endtask

  task automatic push_report(input logic [7:0] d, input logic [7:0] t);
    push(8'hAA, 8'h03);
    push(8'hAA, 8'hB0);
    push(8'hAA, 8'h00);
    push(8'hAA, d);
    push(8'hAA, t);
  endtask

  task automatic push_cmd_hdr(input logic [7:0] c);
    push(c, 8'h55);
    push(8'h00, 8'h61);
    push(8'h00, 8'h01);
    push(8'h00, 8'h01);
  endtask

  task automatic send_cmd(input logic [1:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_mf();
    @(negedge clk);
    mode_fault = 1'b1;
    @(negedge clk);
    mode_fault = 1'b0;
  endtask

  task automatic wait_until_ready(input string tag, input int budget);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, cmd_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_mosi_left(input string tag, input int left, input int budget);
    int n = 0;
    while (exp_mosi.size() > left && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_mosi.size(), left);
  endtask

  initial begin
    // Reset values, then one rejected sync before the good one.
    push(8'hDD, 8'h11);
    push(8'hDD, 8'hEE);
    repeat (3) @(negedge clk);
    check("rst_spi_write", spi_write, 0);
    check("rst_spi_mosi", spi_mosi, 8'hFF);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_status_valid", status_valid, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_disc", disc_state, 0);
    check("rst_tray", tray_state, 0);
    reset_n = 1'b1;
    wait_until_ready("sync_ready", 200);
    check("sync_err_code", err_code, 1);
    check("sync_pe_cnt", pe_cnt, 1);
    check("sync_bytes_used", exp_mosi.size(), 0);

    // Close with CD-i disc.
    push_cmd_hdr(8'hA7);
    push_report(8'h02, 8'h25);
    send_cmd(2'd2);
    wait_mosi_left("close_hdr_done", 5, 200);
    repeat (3) @(negedge clk);
    pulse_mf();
    wait_until_ready("close_done", 200);
    check("close_disc", disc_state, 1);
    check("close_tray", tray_state, 0);
    check("close_sv_cnt", sv_cnt, 1);
    check("close_pe_cnt", pe_cnt, 1);
    check("close_bytes_used", exp_mosi.size(), 0);

    // Open, no disc.
    push_cmd_hdr(8'hA6);
    push_report(8'h03, 8'h21);
    send_cmd(2'd1);
    wait_mosi_left("open_hdr_done", 5, 200);
    repeat (3) @(negedge clk);
    pulse_mf();
    wait_until_ready("open_done", 200);
    check("open_disc", disc_state, 0);
    check("open_tray", tray_state, 1);
    check("open_sv_cnt", sv_cnt, 2);

    // Unsolicited report while idle: first write must be AA, not a command byte.
    push_report(8'h01, 8'h25);
    pulse_mf();
    wait_until_ready("unsol_done", 200);
    check("unsol_disc", disc_state, 2);
    check("unsol_tray", tray_state, 0);
    check("unsol_sv_cnt", sv_cnt, 3);
    check("unsol_bytes_used", exp_mosi.size(), 0);

    // Illegal command code.
    send_cmd(2'd3);
    wait_until_ready("illegal_ready", 10);
    check("illegal_err_code", err_code, 5);
    check("illegal_pe_cnt", pe_cnt, 2);

    // Bad command acknowledge.
    push(8'hB0, 8'h54);
    send_cmd(2'd0);
    wait_until_ready("nak_done", 200);
    check("nak_err_code", err_code, 2);
    check("nak_pe_cnt", pe_cnt, 3);
    check("nak_disc", disc_state, 2);
    check("nak_tray", tray_state, 0);

    // Header good, mode fault never arrives.
    push_cmd_hdr(8'hB0);
    send_cmd(2'd0);
    wait_until_ready("tmo_done", 400);
    check("tmo_err_code", err_code, 4);
    check("tmo_pe_cnt", pe_cnt, 4);
    check("tmo_sv_cnt", sv_cnt, 3);

    // Report with an unknown tray byte leaves outputs alone.
    push_report(8'h02, 8'h22);
    pulse_mf();
    wait_until_ready("badrpt_done", 200);
    check("badrpt_err_code", err_code, 6);
    check("badrpt_pe_cnt", pe_cnt, 5);
    check("badrpt_disc", disc_state, 2);
    check("badrpt_sv_cnt", sv_cnt, 3);

    // Mode fault and command in the same cycle: report first, then the held command.
    push_report(8'h03, 8'h25);
    push(8'hB0, 8'h54);
    @(negedge clk);
    mode_fault = 1'b1;
    cmd_valid  = 1'b1;
    cmd_code   = 2'd0;
    @(negedge clk);
    mode_fault = 1'b0;
    wait_mosi_left("prio_report_done", 1, 200);
    wait_until_ready("prio_idle", 50);
    cmd_valid = 1'b0;
    check("prio_sv_cnt", sv_cnt, 4);
    check("prio_disc", disc_state, 0);
    wait_until_ready("prio_cmd_done", 200);
    check("prio_err_code", err_code, 2);
    check("prio_pe_cnt", pe_cnt, 6);

    // Good unsolicited report (AUDIO, OPEN), then reset mid-report.
    push_report(8'h01, 8'h21);
    pulse_mf();
    wait_until_ready("pre_rst_done", 200);
    check("pre_rst_disc", disc_state, 2);
    check("pre_rst_tray", tray_state, 1);
    push_report(8'h02, 8'h25);
    pulse_mf();
    wait_mosi_left("rst_at_byte2", 2, 200);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_spi_write", spi_write, 0);
    check("midrst_spi_mosi", spi_mosi, 8'hFF);
    check("midrst_disc", disc_state, 0);
    check("midrst_tray", tray_state, 0);
    check("midrst_err_code", err_code, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    exp_mosi.delete();
    miso_q.delete();
    push(8'hDD, 8'hEE);
    @(negedge clk);
    reset_n = 1'b1;
    wait_until_ready("resync_ready", 200);
    check("resync_bytes_used", exp_mosi.size(), 0);
    check("resync_sv_cnt", sv_cnt, 5);
    check("resync_pe_cnt", pe_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
